// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle signed/unsigned multiply and restoring radix-2 divide
module muldiv_unit #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV_PREP,
        S_DIV_ITER,
        S_DIV_FIX
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0]   op_a, op_b;
    logic [1:0]         op_q;
    logic [2*WIDTH-1:0] prod_q, mul_comb, mul_src, ext_a, ext_b;
    logic [1:0]         mul_cnt;
    logic [CW-1:0]      iter_cnt;
    logic [WIDTH-1:0]   mag_b, rem_q, quo_q;
    logic               q_neg, r_neg, b_zero;
    logic               is_signed, neg_a, neg_b;
    logic               accept, mul_done, iter_done;
    logic [WIDTH:0]     shifted, trial;

    assign accept    = start && !cancel && (state == S_IDLE);
    assign mul_done  = (state == S_MUL) && (mul_cnt == 2'(MUL_LAT - 1));
    assign iter_done = (state == S_DIV_ITER) && (iter_cnt == CW'(WIDTH - 1));
    assign busy      = (state != S_IDLE);

    // Operands stay latched for the whole operation, so both signed and
    // unsigned products are a plain 2*WIDTH multiply of the extended values.
    assign is_signed = ~op_q[0];
    assign neg_a     = is_signed & op_a[WIDTH-1];
    assign neg_b     = is_signed & op_b[WIDTH-1];
    assign ext_a     = {{WIDTH{neg_a}}, op_a};
    assign ext_b     = {{WIDTH{neg_b}}, op_b};
    assign mul_comb  = ext_a * ext_b;
    assign mul_src   = (MUL_LAT == 1) ? mul_comb : prod_q;

    // One restoring step: shift in the next dividend bit and try to subtract.
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, mag_b};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (cancel && state != S_IDLE) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:     if (accept) state_nxt = op[1] ? S_DIV_PREP : S_MUL;
                S_MUL:      if (mul_done) state_nxt = S_IDLE;
                S_DIV_PREP: state_nxt = S_DIV_ITER;
                S_DIV_ITER: if (iter_done) state_nxt = S_DIV_FIX;
                S_DIV_FIX:  state_nxt = S_IDLE;
                default:    state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_a         <= '0;
            op_b         <= '0;
            op_q         <= '0;
            prod_q       <= '0;
            mul_cnt      <= '0;
            iter_cnt     <= '0;
            mag_b        <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            q_neg        <= 1'b0;
            r_neg        <= 1'b0;
            b_zero       <= 1'b0;
            result_valid <= 1'b0;
            result_hi    <= '0;
            result_lo    <= '0;
        end else begin
            result_valid <= 1'b0;
            if (accept) begin
                op_a     <= a;
                op_b     <= b;
                op_q     <= op;
                mul_cnt  <= '0;
                iter_cnt <= '0;
            end
            if (!cancel) begin
                case (state)
                    S_MUL: begin
                        prod_q  <= mul_comb;
                        mul_cnt <= mul_cnt + 2'd1;
                        if (mul_done) begin
                            result_hi    <= mul_src[2*WIDTH-1:WIDTH];
                            result_lo    <= mul_src[WIDTH-1:0];
                            result_valid <= 1'b1;
                        end
                    end
                    S_DIV_PREP: begin
                        quo_q    <= neg_a ? -op_a : op_a;
                        mag_b    <= neg_b ? -op_b : op_b;
                        rem_q    <= '0;
                        q_neg    <= neg_a ^ neg_b;
                        r_neg    <= neg_a;
                        b_zero   <= (op_b == '0);
                        iter_cnt <= '0;
                    end
                    S_DIV_ITER: begin
                        if (!trial[WIDTH]) begin
                            rem_q <= trial[WIDTH-1:0];
                            quo_q <= {quo_q[WIDTH-2:0], 1'b1};
                        end else begin
                            rem_q <= shifted[WIDTH-1:0];
                            quo_q <= {quo_q[WIDTH-2:0], 1'b0};
                        end
                        iter_cnt <= iter_cnt + CW'(1);
                    end
                    S_DIV_FIX: begin
                        // Divide by zero bypasses sign fixup: all-ones quotient, dividend as remainder.
                        if (b_zero) begin
                            result_lo <= '1;
                            result_hi <= op_a;
                        end else begin
                            result_lo <= q_neg ? -quo_q : quo_q;
                            result_hi <= r_neg ? -rem_q : rem_q;
                        end
                        result_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        cancel;
    logic        busy, result_valid;
    logic [31:0] result_hi, result_lo;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] last_res = '0;

    muldiv_unit #(.WIDTH(32), .MUL_LAT(2)) dut (
        .clk(clk), .resetn(resetn), .start(start), .op(op), .a(a), .b(b),
        .cancel(cancel), .busy(busy), .result_valid(result_valid),
        .result_hi(result_hi), .result_lo(result_lo)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] ux, uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'h0, x};
        uy = {32'h0, y};
        case (o)
            2'd0: return 64'(sx * sy);
            2'd1: return ux * uy;
            default: begin
                if (y == 32'h0) return {x, 32'hFFFFFFFF};
                if (o == 2'd2) begin
                    if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
                    q = sx / sy;
                    r = sx % sy;
                    return {r[31:0], q[31:0]};
                end
                return {x % y, x / y};
            end
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives the request now, so calling it in a result_valid cycle tests back-to-back issue.
    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input string tag);
        logic [63:0] exp;
        int lat, edges;
        bit got;
        exp = model(o, x, y);
        lat = o[1] ? 34 : 2;
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom; op = 2'(($urandom));
        chk({tag, " busy_after_accept"}, 64'(busy), 64'd1);
        edges = 0;
        got = 0;
        while (!got && edges < 100) begin
            @(posedge clk); #1;
            edges++;
            if (result_valid) got = 1;
            else if (busy !== 1'b1) chk({tag, " busy_during_op"}, 64'(busy), 64'd1);
        end
        chk({tag, " got_valid"}, 64'(got), 64'd1);
        chk({tag, " latency"}, 64'(edges), 64'(lat));
        chk({tag, " result"}, {result_hi, result_lo}, exp);
        chk({tag, " busy_in_valid"}, 64'(busy), 64'd0);
        last_res = exp;
    endtask

    task automatic watch_no_valid(input int n, input string tag);
        int seen = 0;
        repeat (n) begin
            @(posedge clk); #1;
            if (result_valid) seen++;
        end
        chk(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        int edges;
        bit got;
        logic [31:0] x, y;
        logic [1:0] o;
        logic [63:0] exp;

        resetn = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; cancel = 1'b0;
        #12;
        chk("reset_outputs", {30'h0, busy, result_valid, result_hi, result_lo}, 64'h0);
        @(negedge clk); resetn = 1'b1;

        @(negedge clk); do_op(2'd0, 32'hFFFFFFFE, 32'd3, "mult_neg");
        @(posedge clk); #1;
        chk("valid_one_cycle", 64'(result_valid), 64'd0);
        chk("result_hold", {result_hi, result_lo}, 64'hFFFFFFFF_FFFFFFFA);

        @(negedge clk); do_op(2'd1, 32'hFFFFFFFE, 32'd3, "multu");
        chk("multu_value", {result_hi, result_lo}, 64'h00000002_FFFFFFFA);
        do_op(2'd0, 32'h12345678, 32'h9ABCDEF0, "b2b_mult");
        do_op(2'd3, 32'd100, 32'd7, "b2b_divu");

        @(negedge clk); do_op(2'd2, 32'hFFFFFFF9, 32'd2, "div_neg");
        chk("div_neg_value", {result_hi, result_lo}, 64'hFFFFFFFF_FFFFFFFD);
        @(negedge clk); do_op(2'd3, 32'd7, 32'd2, "divu");
        chk("divu_value", {result_hi, result_lo}, 64'h00000001_00000003);
        @(negedge clk); do_op(2'd3, 32'd7, 32'd0, "divu_by0");
        chk("divu_by0_value", {result_hi, result_lo}, 64'h00000007_FFFFFFFF);
        @(negedge clk); do_op(2'd2, 32'hFFFFFFF9, 32'd0, "div_by0");
        @(negedge clk); do_op(2'd2, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
        chk("div_ovf_value", {result_hi, result_lo}, 64'h00000000_80000000);
        @(negedge clk); do_op(2'd2, 32'd7, 32'hFFFFFFFE, "div_pos_neg");
        @(negedge clk); do_op(2'd0, 32'h80000000, 32'h80000000, "mult_minmin");

        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom);
            x = $urandom;
            case ($urandom_range(0, 3))
                0: y = 32'h0;
                1: y = 32'($urandom_range(1, 20));
                2: y = -32'($urandom_range(1, 20));
                default: y = $urandom;
            endcase
            if ($urandom_range(0, 1) == 1) @(negedge clk);
            do_op(o, x, y, "random");
        end

        @(negedge clk); start = 1'b1; cancel = 1'b1; op = 2'd0; a = 32'd5; b = 32'd5;
        @(posedge clk); #1;
        start = 1'b0; cancel = 1'b0;
        chk("start_with_cancel_ignored", 64'(busy), 64'd0);
        watch_no_valid(4, "start_with_cancel_no_valid");

        @(negedge clk); start = 1'b1; op = 2'd2; a = $urandom; b = $urandom | 32'h1;
        @(posedge clk); #1; start = 1'b0;
        repeat (10) @(posedge clk);
        #1; cancel = 1'b1;
        @(posedge clk); #1; cancel = 1'b0;
        chk("cancel_busy", 64'(busy), 64'd0);
        chk("cancel_valid", 64'(result_valid), 64'd0);
        chk("cancel_hold", {result_hi, result_lo}, last_res);
        do_op(2'd1, 32'hDEADBEEF, 32'h00010001, "after_cancel");
        watch_no_valid(40, "cancel_no_late_valid");

        @(negedge clk); start = 1'b1; cancel = 1'b1; op = 2'd0; a = 32'd1; b = 32'd1;
        @(posedge clk); #1; start = 1'b0; cancel = 1'b0;
        chk("cancel_idle_no_effect", {31'h0, busy, result_hi}, {32'h0, last_res[63:32]});

        x = 32'hFFFF0123; y = 32'h00000345;
        exp = model(2'd2, x, y);
        @(negedge clk); start = 1'b1; op = 2'd2; a = x; b = y;
        @(posedge clk); #1; start = 1'b0;
        repeat (4) @(posedge clk);
        #1; start = 1'b1; op = 2'd0; a = 32'd9; b = 32'd9;
        @(posedge clk); #1; start = 1'b0;
        edges = 5;
        got = 0;
        while (!got && edges < 100) begin
            @(posedge clk); #1;
            edges++;
            if (result_valid) got = 1;
        end
        chk("busy_start_latency", 64'(edges), 64'd34);
        chk("busy_start_result", {result_hi, result_lo}, exp);
        watch_no_valid(10, "busy_start_no_second");

        @(negedge clk); start = 1'b1; op = 2'd3; a = 32'd1000; b = 32'd3;
        @(posedge clk); #1; start = 1'b0;
        repeat (10) @(posedge clk);
        #2; resetn = 1'b0;
        #1;
        chk("async_reset_outputs", {30'h0, busy, result_valid, result_hi, result_lo}, 64'h0);
        #2; resetn = 1'b1;
        watch_no_valid(50, "reset_no_valid");
        chk("reset_idle", 64'(busy), 64'd0);
        @(negedge clk); do_op(2'd3, 32'd1000, 32'd3, "after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
